coin_button_conditioner: RTL and testbench

- Front-end stage that conditions the three raw coin/selection pushbuttons before they reach the vending-machine FSM.
- Each raw input is synchronised and debounced. A rising edge of the debounced level becomes a single-cycle pulse.
- Per press: at most one one-hot pulse per event, followed by a hold-off window, so the FSM sees exactly one 25/50/100 Krs event per physical press.

---
 rtl/coin_button_conditioner.sv | 138 +++++++++++++
 tb/tb_coin_button_conditioner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/coin_button_conditioner.sv
// Coin/selection button front end: sync, debounce, rising-edge pulse,
// one-hot arbitration and a post-pulse hold-off window.
module coin_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 2,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn1_raw,
  input  logic       btn2_raw,
  input  logic       btn3_raw,
  output logic       btn1_pulse,
  output logic       btn2_pulse,
  output logic       btn3_pulse,
  output logic [2:0] btn_stable,
  output logic       busy,
  output logic [7:0] press_count
);

  localparam int HW = (HOLDOFF_CYCLES > 0) ?
    $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       stable;
  logic [2:0]       stable_d;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       rise;
  logic [2:0]       win;

  state_t           state_q;
  state_t           state_d;
  logic [HW-1:0]    hold_q;
  logic [HW-1:0]    hold_d;
  logic [2:0]       pulse_q;
  logic [2:0]       pulse_d;
  logic [7:0]       press_q;
  logic [7:0]       press_d;

  // Two-flop synchroniser for the asynchronous raw buttons.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn3_raw, btn2_raw, btn1_raw};
      sync2 <= sync1;
    end
  end

  // Accept a new level only after a full run of differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = stable & ~stable_d;

  // Fixed priority: btn1 over btn2 over btn3; losers are dropped.
  always_comb begin
    win = 3'b000;
    if (rise[0])      win = 3'b001;
    else if (rise[1]) win = 3'b010;
    else if (rise[2]) win = 3'b100;
  end

  // Pulse/hold-off state register and diagnostic counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      pulse_q <= '0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pulse_q <= pulse_d;
      press_q <= press_d;
    end
  end

  // Next state: emit one pulse, then ignore rises for the hold-off.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pulse_d = 3'b000;
    press_d = press_q;
    unique case (state_q)
      IDLE: begin
        if (|rise) begin
          pulse_d = win;
          if (press_q != 8'hFF) press_d = press_q + 8'd1;
          if (HOLDOFF_CYCLES > 0) begin
            hold_d  = HOLD_INIT;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        hold_d = hold_q - HW'(1);
        if (hold_q == HW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign btn1_pulse  = pulse_q[0];
  assign btn2_pulse  = pulse_q[1];
  assign btn3_pulse  = pulse_q[2];
  assign btn_stable  = stable;
  assign press_count = press_q;
  assign busy        = (|pulse_q) | (state_q == HOLD);

endmodule

// File: tb/tb_coin_button_conditioner.sv
// Scoreboard bench for coin_button_conditioner with a window-based
// reference model of debounce, arbitration and hold-off.
module tb_coin_button_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 2;

  logic       clk;
  logic       reset;
  logic [2:0] raw;
  logic       btn1_pulse;
  logic       btn2_pulse;
  logic       btn3_pulse;
  logic [2:0] btn_stable;
  logic       busy;
  logic [7:0] press_count;

  coin_button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn1_raw(raw[0]),
    .btn2_raw(raw[1]),
    .btn3_raw(raw[2]),
    .btn1_pulse(btn1_pulse),
    .btn2_pulse(btn2_pulse),
    .btn3_pulse(btn3_pulse),
    .btn_stable(btn_stable),
    .busy(busy),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] p;
  } ev_t;

  ev_t  sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // model state
  logic [2:0]  m_s1 = '0;
  logic [2:0]  m_s2 = '0;
  logic [31:0] m_hist [3] = '{32'd0, 32'd0, 32'd0};
  logic [2:0]  m_stab   = '0;
  logic [2:0]  m_stab_d = '0;
  int          m_hold   = 0;
  logic [2:0]  m_pulse  = '0;
  int          m_cnt    = 0;
  logic        m_busy;

  // Reference model: a level is taken when the last DEB samples
  // all disagree with it; rises inside the hold window are lost.
  always @(posedge clk) begin
    logic [2:0]  r;
    logic [31:0] mask;
    logic [31:0] w;
    ev_t         e;
    cyc++;
    mask = (32'd1 << DEB) - 32'd1;
    if (reset) begin
      m_s1 = '0; m_s2 = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
      m_stab = '0; m_stab_d = '0;
      m_hold = 0; m_pulse = '0; m_cnt = 0;
      sbq.delete();
    end else begin
      r = m_stab & ~m_stab_d;
      m_pulse = '0;
      if (m_hold > 0) begin
        m_hold--;
      end else if (r != 0) begin
        for (int b = 2; b >= 0; b--) if (r[b]) m_pulse = 3'b001 << b;
        m_hold = HOLD;
        if (m_cnt < 255) m_cnt++;
        e.cyc = cyc;
        e.p = m_pulse;
        sbq.push_back(e);
      end
      m_stab_d = m_stab;
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = {m_hist[b][30:0], m_s2[b]};
        w = m_hist[b] & mask;
        if ((m_stab[b] == 1'b0 && w == mask) ||
            (m_stab[b] == 1'b1 && w == 32'd0))
          m_stab[b] = m_s2[b];
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    m_busy = (m_pulse != 0) || (m_hold > 0);
  end

  // Monitor: level checks every cycle, pulses against the queue.
  always @(negedge clk) begin
    logic [2:0] p;
    ev_t        e;
    p = {btn3_pulse, btn2_pulse, btn1_pulse};
    total++;
    if (btn_stable !== m_stab) begin
      bad++;
      $display("FAIL stable cyc=%0d got=%b exp=%b",
               cyc, btn_stable, m_stab);
    end
    total++;
    if (busy !== m_busy) begin
      bad++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy);
    end
    total++;
    if (press_count !== 8'(m_cnt)) begin
      bad++;
      $display("FAIL count cyc=%0d got=%0d exp=%0d",
               cyc, press_count, m_cnt);
    end
    if (p != 0) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL extra_pulse cyc=%0d got=%b exp=none", cyc, p);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != cyc || e.p !== p) begin
          bad++;
          $display("FAIL pulse cyc=%0d got=%b exp=%b@%0d",
                   cyc, p, e.p, e.cyc);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      total++;
      bad++;
      e = sbq.pop_front();
      $display("FAIL missing_pulse cyc=%0d got=000 exp=%b", cyc, e.p);
    end
  end

  task automatic drive(input logic [2:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #2 raw = v;
    end
  endtask

  task automatic toggle(input int bit_i, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #2 raw[bit_i] = ~raw[bit_i];
    end
  endtask

  task automatic check_reset_outputs();
    total++;
    if ({btn3_pulse, btn2_pulse, btn1_pulse, btn_stable, busy} != 0 ||
        press_count != 0) begin
      bad++;
      $display("FAIL async_reset got=%b%b%b %b %b %0d exp=all zero",
               btn3_pulse, btn2_pulse, btn1_pulse,
               btn_stable, busy, press_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    raw   = 3'b000;
    drive(3'b000, 3);
    #1 reset = 1'b0;
    drive(3'b000, 4);

    // clean press
    drive(3'b001, 20);
    drive(3'b000, 12);

    // bounce on press and release of btn2
    raw[1] = 1'b0;
    toggle(1, 4);
    drive(3'b010, 20);
    toggle(1, 4);
    drive(3'b000, 12);

    // short glitch on btn3
    drive(3'b100, 3);
    drive(3'b000, 12);

    // simultaneous btn1 + btn3
    drive(3'b101, 20);
    drive(3'b000, 12);

    // btn2 rising at various offsets after btn1
    for (int lag = 1; lag <= 4; lag++) begin
      drive(3'b001, lag);
      drive(3'b011, 16);
      drive(3'b000, 12);
    end

    // random raw activity with bounce
    for (int k = 0; k < 200; k++)
      drive(3'($urandom_range(0, 7)), $urandom_range(1, 7));
    drive(3'b000, 12);

    // reset in the middle of a btn1 debounce
    drive(3'b001, 3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs();
    drive(3'b001, 3);
    #1 reset = 1'b0;
    drive(3'b001, 20);
    drive(3'b000, 12);

    // saturation of the press counter
    for (int k = 0; k < 300; k++) begin
      drive(3'b001, 8);
      drive(3'b000, 8);
    end
    drive(3'b000, 4);
    total++;
    if (press_count != 8'd255) begin
      bad++;
      $display("FAIL saturate got=%0d exp=255", press_count);
    end

    drive(3'b000, 12);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL pending_pulses got=%0d exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
